// File: rtl/sfq_coincidence_gate.sv
// sfq_coincidence_gate
//   Clocked coincidence gate for toggle-encoded SFQ pulse lines. Each edge on
//   an in_tog line is one pulse. When THRESH distinct lines have pulsed inside
//   a WINDOW-cycle window, q toggles once and fire strobes. A programmable
//   threshold covers AND (N_IN), majority and OR (1) behaviour. Re-pulsing a
//   line inside a window raises dup_err. A window that expires without firing
//   raises timeout. After each fire, a HOLDOFF dead time models junction
//   recovery. A saturating counter tracks the number of fires.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   in_tog    N_IN toggle-encoded pulse inputs
//   thresh    distinct inputs required; 0 or > N_IN means N_IN
//   q         toggle-encoded output pulse
//   fire      one-cycle strobe, coincident with the q toggle
//   armed     high while a coincidence window is open
//   timeout   one-cycle strobe when a window expires without firing
//   dup_err   one-cycle strobe when an already-seen input pulses again
//   fire_cnt  saturating count of fires
module sfq_coincidence_gate #(
  parameter int N_IN    = 4,
  parameter int WINDOW  = 8,
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 16,
  localparam int TW     = $clog2(N_IN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_tog,
  input  logic [TW-1:0]    thresh,
  output logic             q,
  output logic             fire,
  output logic             armed,
  output logic             timeout,
  output logic             dup_err,
  output logic [CNT_W-1:0] fire_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // One counter serves both the window and the holdoff, so size it for the
  // larger of the two.
  localparam int CMAX_A = (WINDOW > HOLDOFF) ? WINDOW : HOLDOFF;
  localparam int CMAX   = (CMAX_A > 2) ? CMAX_A : 2;
  localparam int CW     = $clog2(CMAX);

  // In ARMED, win_cnt lags the window cycle number by one: cycle 0 is spent
  // in IDLE. Therefore the last cycle of the window, WINDOW-1, shows up as
  // win_cnt == WINDOW-2.
  localparam logic [CW-1:0] ARM_LAST  = CW'((WINDOW >= 2) ? WINDOW - 2 : 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'((HOLDOFF >= 1) ? HOLDOFF - 1 : 0);

  logic [1:0]      state;
  logic [N_IN-1:0] prev_in;
  logic [N_IN-1:0] seen;
  logic [CW-1:0]   win_cnt;
  logic [TW-1:0]   th_r;

  logic [N_IN-1:0] pv;
  logic [N_IN-1:0] merged;
  logic [N_IN-1:0] dup_bits;
  logic [TW-1:0]   eff_th;
  logic            fire_now;
  logic            timeout_now;
  logic            dup_now;

  function automatic logic [TW-1:0] popcount(input logic [N_IN-1:0] v);
    logic [TW-1:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) begin
      c = c + TW'(v[i]);
    end
    return c;
  endfunction

  assign armed = (state == ST_ARMED);

  // Fire takes priority over timeout. This lets a pulse in the last window
  // cycle still complete the coincidence. A duplicate is flagged independently
  // of whether the gate fires in the same cycle.
  always_comb begin
    pv          = in_tog ^ prev_in;
    merged      = seen | pv;
    dup_bits    = pv & seen;
    eff_th      = ((thresh == '0) || (thresh > TW'(N_IN))) ? TW'(N_IN) : thresh;
    fire_now    = 1'b0;
    timeout_now = 1'b0;
    dup_now     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pv != '0) begin
          if (popcount(pv) >= eff_th) begin
            fire_now = 1'b1;
          end else if (WINDOW == 1) begin
            timeout_now = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        dup_now = |dup_bits;
        if (popcount(merged) >= th_r) begin
          fire_now = 1'b1;
        end else if (win_cnt == ARM_LAST) begin
          timeout_now = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // prev_in tracks in_tog even during reset. A line held in a toggled state
  // across reset release therefore does not appear as a pulse.
  always_ff @(posedge clk) begin
    prev_in <= in_tog;
    if (rst) begin
      state    <= ST_IDLE;
      seen     <= '0;
      win_cnt  <= '0;
      th_r     <= '0;
      q        <= 1'b0;
      fire     <= 1'b0;
      timeout  <= 1'b0;
      dup_err  <= 1'b0;
      fire_cnt <= '0;
    end else begin
      fire    <= fire_now;
      timeout <= timeout_now;
      dup_err <= dup_now;
      if (fire_now) begin
        q       <= ~q;
        seen    <= '0;
        win_cnt <= '0;
        if (fire_cnt != '1) begin
          fire_cnt <= fire_cnt + 1'b1;
        end
        if (state == ST_IDLE) begin
          th_r <= eff_th;
        end
        state <= (HOLDOFF > 0) ? ST_HOLD : ST_IDLE;
      end else if (timeout_now) begin
        seen    <= '0;
        win_cnt <= '0;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pv != '0) begin
              seen    <= pv;
              th_r    <= eff_th;
              win_cnt <= '0;
              state   <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            seen    <= merged;
            win_cnt <= win_cnt + 1'b1;
          end
          ST_HOLD: begin
            if (win_cnt == HOLD_LAST) begin
              win_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              win_cnt <= win_cnt + 1'b1;
            end
          end
          default: begin
            seen    <= '0;
            win_cnt <= '0;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
